// File: rtl/collision_scorer_if.sv
// Bundles the per-frame game inputs and the scorer's result outputs.
// The game core drives through the master modport; collision_scorer uses the slave modport.
interface collision_scorer_if #(
  parameter int N_BARS  = 3,
  parameter int SCORE_W = 10
);
  logic                  frame_tick;
  logic                  game_start;
  logic [9:0]            bruin_x;
  logic [9:0]            bruin_y;
  logic [4:0]            bruin_w;
  logic [4:0]            bruin_h;
  logic [N_BARS*10-1:0]  x_bar;
  logic [N_BARS*10-1:0]  y_gap;
  logic [N_BARS-1:0]     wraps;
  logic                  lose;
  logic [SCORE_W-1:0]    score;
  logic                  score_pulse;
  logic [SCORE_W-1:0]    high_score;
  logic [1:0]            state;

  modport master (
    output frame_tick, game_start, bruin_x, bruin_y, bruin_w, bruin_h,
           x_bar, y_gap, wraps,
    input  lose, score, score_pulse, high_score, state
  );

  modport slave (
    input  frame_tick, game_start, bruin_x, bruin_y, bruin_w, bruin_h,
           x_bar, y_gap, wraps,
    output lose, score, score_pulse, high_score, state
  );
endinterface

// File: rtl/collision_scorer.sv
// Per-frame collision detection, pass scoring and game-state FSM for a flappy-style game.
// Define HIGH_SCORE_EN to keep a best-score register that survives restarts.
module collision_scorer #(
  parameter int N_BARS   = 3,
  parameter int BAR_W    = 40,
  parameter int GAP_H    = 120,
  parameter int SCORE_W  = 10,
  parameter int SCREEN_H = 480
) (
  input  logic              clk_25MHz,
  input  logic              reset,
  collision_scorer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } state_t;

  localparam logic [10:0]        BAR_W_W   = 11'(BAR_W);
  localparam logic [10:0]        HALF_GAP  = 11'(GAP_H / 2);
  localparam logic [10:0]        FLOOR_Y   = 11'(SCREEN_H - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t              state_q, state_d;
  logic                lose_q, lose_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic                pulse_q, pulse_d;
  logic [N_BARS-1:0]   armed_q, armed_d;

  logic [10:0]         birdX, birdY, halfW, halfH;
  logic [10:0]         birdL, birdR;
  logic [N_BARS-1:0]   barHit, barPass;
  logic                edgeHit, evalTick, anyHit, enterPlay;
  logic [3:0]          passCount;
  logic [SCORE_W+3:0]  scoreSum;
  logic [SCORE_W-1:0]  scoreSat;

  // All geometry is widened to 11 bits and subtractions floor at zero.
  function automatic logic [10:0] subClamp(input logic [10:0] a, input logic [10:0] b);
    return (a >= b) ? (a - b) : 11'd0;
  endfunction

  assign birdX = 11'(bus.bruin_x);
  assign birdY = 11'(bus.bruin_y);
  assign halfW = 11'(bus.bruin_w >> 1);
  assign halfH = 11'(bus.bruin_h >> 1);
  assign birdL = subClamp(birdX, halfW);
  assign birdR = birdX + halfW;

  assign edgeHit = ((birdY + halfH) >= FLOOR_Y) || (birdY < halfH);

  always_comb begin : barGeometry
    logic [10:0] xb;
    logic [10:0] yg;
    xb      = '0;
    yg      = '0;
    barHit  = '0;
    barPass = '0;
    for (int i = 0; i < N_BARS; i++) begin
      xb = 11'(bus.x_bar[10*i +: 10]);
      yg = 11'(bus.y_gap[10*i +: 10]);
      barHit[i]  = (birdR >= subClamp(xb, BAR_W_W)) && (birdL <= xb) &&
                   ((birdY < subClamp(yg, HALF_GAP)) || (birdY > (yg + HALF_GAP)));
      barPass[i] = (birdL > xb) && armed_q[i];
    end
  end

  always_comb begin
    passCount = '0;
    for (int i = 0; i < N_BARS; i++) begin
      passCount = passCount + 4'(barPass[i]);
    end
  end

  assign scoreSum = {4'b0, score_q} + {{SCORE_W{1'b0}}, passCount};
  assign scoreSat = (scoreSum > {4'b0, SCORE_MAX}) ? SCORE_MAX : scoreSum[SCORE_W-1:0];

  assign evalTick  = bus.frame_tick && (state_q == PLAY);
  assign anyHit    = evalTick && ((|barHit) || edgeHit);
  assign enterPlay = bus.game_start && ((state_q == IDLE) || (state_q == OVER));

  always_ff @(posedge clk_25MHz) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.game_start) state_d = PLAY;
      PLAY:    if (anyHit)         state_d = OVER;
      OVER:    if (bus.game_start) state_d = PLAY;
      default: state_d = IDLE;
    endcase
  end

  // A hit freezes score and armed bits; respawn re-arms a bar regardless of state or pass.
  always_comb begin
    lose_d  = lose_q;
    score_d = score_q;
    pulse_d = 1'b0;
    armed_d = armed_q;
    if (enterPlay) begin
      score_d = '0;
      lose_d  = 1'b0;
      armed_d = '1;
    end else if (anyHit) begin
      lose_d = 1'b1;
    end else if (evalTick) begin
      armed_d = armed_q & ~barPass;
      score_d = scoreSat;
      pulse_d = (scoreSat != score_q);
    end
    armed_d = armed_d | bus.wraps;
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      lose_q  <= 1'b0;
      score_q <= '0;
      pulse_q <= 1'b0;
      armed_q <= '1;
    end else begin
      lose_q  <= lose_d;
      score_q <= score_d;
      pulse_q <= pulse_d;
      armed_q <= armed_d;
    end
  end

`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] highScore_q, highScore_d;

  always_comb begin
    highScore_d = highScore_q;
    if (anyHit && (score_q > highScore_q)) highScore_d = score_q;
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) highScore_q <= '0;
    else       highScore_q <= highScore_d;
  end

  assign bus.high_score = highScore_q;
`else
  assign bus.high_score = '0;
`endif

  assign bus.state       = state_q;
  assign bus.lose        = lose_q;
  assign bus.score       = score_q;
  assign bus.score_pulse = pulse_q;

endmodule

// File: tb/tb_collision_scorer.sv
// Self-checking bench for collision_scorer: directed game scenarios pinned with literals,
// then randomized play compared every cycle against an integer game model.
module tb_collision_scorer;

  localparam int N_BARS    = 3;
  localparam int BAR_W     = 40;
  localparam int GAP_H     = 120;
  localparam int SCORE_W   = 4;
  localparam int SCREEN_H  = 480;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  logic clk = 1'b0;
  logic reset;

  collision_scorer_if #(.N_BARS(N_BARS), .SCORE_W(SCORE_W)) bus ();

  collision_scorer #(
    .N_BARS(N_BARS), .BAR_W(BAR_W), .GAP_H(GAP_H), .SCORE_W(SCORE_W), .SCREEN_H(SCREEN_H)
  ) dut (
    .clk_25MHz(clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #20 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Game model: 0 idle, 1 playing, 2 game over.
  int       mState, mLose, mScore, mPulse, mHigh;
  bit [7:0] mArmed;

  function automatic int sub0(input int a, input int b);
    return (a > b) ? a - b : 0;
  endfunction

  task automatic modelStep();
    int  bx, by, hw, hh, xb, yg, passes, newScore;
    bit  hit;
    bx = int'(bus.bruin_x);
    by = int'(bus.bruin_y);
    hw = int'(bus.bruin_w) / 2;
    hh = int'(bus.bruin_h) / 2;
    hit = (by + hh >= SCREEN_H - 1) || (by < hh);
    for (int i = 0; i < N_BARS; i++) begin
      xb = int'(bus.x_bar[10*i +: 10]);
      yg = int'(bus.y_gap[10*i +: 10]);
      if (bx + hw >= sub0(xb, BAR_W) && sub0(bx, hw) <= xb &&
          (by < sub0(yg, GAP_H / 2) || by > yg + GAP_H / 2))
        hit = 1'b1;
    end
    mPulse = 0;
    if (reset) begin
      mState = 0; mLose = 0; mScore = 0; mHigh = 0; mArmed = '1;
    end else begin
      if (mState == 0 || mState == 2) begin
        if (bus.game_start) begin
          mState = 1; mScore = 0; mLose = 0; mArmed = '1;
        end
      end else if (bus.frame_tick) begin
        if (hit) begin
`ifdef HIGH_SCORE_EN
          if (mScore > mHigh) mHigh = mScore;
`endif
          mState = 2;
          mLose  = 1;
        end else begin
          passes = 0;
          for (int i = 0; i < N_BARS; i++) begin
            if (mArmed[i] && sub0(bx, hw) > int'(bus.x_bar[10*i +: 10])) begin
              passes++;
              mArmed[i] = 1'b0;
            end
          end
          newScore = (mScore + passes > SCORE_MAX) ? SCORE_MAX : mScore + passes;
          mPulse   = (newScore != mScore) ? 1 : 0;
          mScore   = newScore;
        end
      end
      for (int i = 0; i < N_BARS; i++) if (bus.wraps[i]) mArmed[i] = 1'b1;
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("state",       32'(bus.state),       mState);
    checkVal("lose",        32'(bus.lose),        mLose);
    checkVal("score",       32'(bus.score),       mScore);
    checkVal("score_pulse", 32'(bus.score_pulse), mPulse);
    checkVal("high_score",  32'(bus.high_score),  mHigh);
  endtask

  // One clock: model consumes the current inputs, then outputs are compared at the falling edge.
  task automatic applyStimulus();
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    applyStimulus();
    bus.frame_tick = 1'b0;
  endtask

  task automatic pulseWraps(input logic [N_BARS-1:0] w);
    bus.wraps = w;
    applyStimulus();
    bus.wraps = '0;
  endtask

  task automatic pulseStart();
    bus.game_start = 1'b1;
    applyStimulus();
    bus.game_start = 1'b0;
  endtask

  task automatic setBars(input int x0, input int g0, input int x1, input int g1,
                         input int x2, input int g2);
    bus.x_bar = {10'(x2), 10'(x1), 10'(x0)};
    bus.y_gap = {10'(g2), 10'(g1), 10'(g0)};
  endtask

  function automatic int expHigh(input int v);
`ifdef HIGH_SCORE_EN
    return v;
`else
    return (v == 0) ? 0 : 0;
`endif
  endfunction

  initial begin
    int gy;
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.game_start = 1'b0;
    bus.wraps      = '0;
    bus.bruin_x    = 10'd100;
    bus.bruin_y    = 10'd240;
    bus.bruin_w    = 5'd16;
    bus.bruin_h    = 5'd16;
    setBars(600, 240, 600, 240, 600, 240);
    mState = 0; mLose = 0; mScore = 0; mPulse = 0; mHigh = 0; mArmed = '1;

    applyStimulus();
    checkVal("rst_state", 32'(bus.state), 0);
    checkVal("rst_score", 32'(bus.score), 0);
    checkVal("rst_lose",  32'(bus.lose), 0);
    reset = 1'b0;
    tick();
    checkVal("idle_tick_ignored", 32'(bus.state), 0);

    pulseStart();
    setBars(300, 240, 600, 240, 600, 240);
    tick();
    checkVal("play_state", 32'(bus.state), 1);
    checkVal("play_score", 32'(bus.score), 0);
    checkVal("play_lose",  32'(bus.lose), 0);

    setBars(90, 240, 600, 240, 600, 240);
    tick();
    checkVal("pass_score", 32'(bus.score), 1);
    checkVal("pass_pulse", 32'(bus.score_pulse), 1);
    applyStimulus();
    checkVal("pulse_one_cycle", 32'(bus.score_pulse), 0);
    tick();
    checkVal("disarmed_score", 32'(bus.score), 1);
    pulseWraps(3'b001);
    tick();
    checkVal("rearm_score", 32'(bus.score), 2);

    pulseWraps(3'b001);
    setBars(90, 240, 110, 100, 600, 240);
    tick();
    checkVal("hit_lose",  32'(bus.lose), 1);
    checkVal("hit_state", 32'(bus.state), 2);
    checkVal("hit_no_score", 32'(bus.score), 2);
    checkVal("hit_high", 32'(bus.high_score), expHigh(2));

    pulseStart();
    checkVal("restart_lose",  32'(bus.lose), 0);
    checkVal("restart_score", 32'(bus.score), 0);
    checkVal("restart_state", 32'(bus.state), 1);
    setBars(600, 240, 600, 240, 600, 240);
    bus.bruin_y = 10'd472;
    tick();
    checkVal("ground_lose", 32'(bus.lose), 1);
    bus.bruin_y = 10'd240;

    pulseStart();
    setBars(50, 240, 600, 240, 50, 240);
    tick();
    checkVal("double_pass", 32'(bus.score), 2);
    for (int k = 0; k < 6; k++) begin
      pulseWraps(3'b101);
      tick();
    end
    checkVal("score_14", 32'(bus.score), 14);
    pulseWraps(3'b101);
    tick();
    checkVal("saturate", 32'(bus.score), 15);
    checkVal("saturate_pulse", 32'(bus.score_pulse), 1);
    pulseWraps(3'b101);
    tick();
    checkVal("held_max", 32'(bus.score), 15);
    checkVal("held_no_pulse", 32'(bus.score_pulse), 0);
    bus.bruin_y = 10'd472;
    tick();
    checkVal("high_15", 32'(bus.high_score), expHigh(15));
    bus.bruin_y = 10'd240;

    pulseStart();
    tick();
    setBars(600, 240, 110, 100, 600, 240);
    tick();
    checkVal("high_kept", 32'(bus.high_score), expHigh(15));
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    checkVal("high_reset", 32'(bus.high_score), 0);

    for (int c = 0; c < 4000; c++) begin
      reset          = ($urandom_range(0, 299) == 0);
      bus.game_start = ($urandom_range(0, 9) == 0);
      bus.frame_tick = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < N_BARS; i++) bus.wraps[i] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.bruin_x = 10'($urandom_range(0, 1023));
        bus.bruin_y = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023))
                                                  : 10'($urandom_range(10, 470));
        bus.bruin_w = 5'($urandom);
        bus.bruin_h = 5'($urandom);
        for (int i = 0; i < N_BARS; i++) begin
          bus.x_bar[10*i +: 10] = 10'($urandom_range(0, 1023));
          gy = int'(bus.bruin_y) + $urandom_range(0, 140) - 70;
          if (gy < 0) gy = 0;
          if (gy > 1023) gy = 1023;
          bus.y_gap[10*i +: 10] = ($urandom_range(0, 1) == 0) ? 10'(gy)
                                                              : 10'($urandom_range(0, 1023));
        end
      end
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
